// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : shared constants and helpers for the UART receive/transmit path
// Rev 1.0
// ==========================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_DELIVER   = 3'd5;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

  // Wide enough to hold CLKS_PER_BIT itself, not just CLKS_PER_BIT-1.
  function automatic int timer_width(input int clks);
    return $clog2(clks + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ==========================================================================
// uart_bit_timer : loadable bit-period down-counter with auto-reload
// Rev 1.0
// ==========================================================================
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load,
  input  logic [timer_width(CLKS_PER_BIT)-1:0] load_val,
  input  logic                                 en,
  output logic                                 expire
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] C_RELOAD = TW'(CLKS_PER_BIT);

  logic [TW-1:0] r_count;

  // Loading N yields an expiry pulse N enabled cycles later.
  assign expire = en && (r_count == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= expire ? C_RELOAD : r_count - TW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ==========================================================================
// uart_rx_param : parametrised RS-232 receiver, 3-tap majority bit sampling
// Rev 1.0
// ==========================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] C_HALF_BIT  = TW'(CLKS_PER_BIT / 2);
  localparam logic [3:0]    C_LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);

  logic                 r_sync1, r_sync2, r_sync3;
  logic [2:0]           r_state;
  logic                 r_pend, r_tap0, r_tap1;
  logic [3:0]           r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr, r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_fall, w_load, w_tmr_en, w_expire, w_maj, w_par_bad;

  assign w_fall   = r_sync3 & ~r_sync2;
  assign w_load   = (r_state == ST_IDLE) && w_fall;
  assign w_tmr_en = (r_state == ST_START) || (r_state == ST_DATA) ||
                    (r_state == ST_PARITY) || (r_state == ST_STOP);

  // Taps at expiry-1 and expiry are held; the third tap is the live value
  // one cycle later, so every bit decision lands on expiry+1 (r_pend).
  assign w_maj = (r_tap0 & r_tap1) | (r_tap0 & r_sync2) | (r_tap1 & r_sync2);

  generate
    if (PARITY == PAR_EVEN) begin : g_par_even
      assign w_par_bad = (^r_shift) ^ w_maj;
    end else if (PARITY == PAR_ODD) begin : g_par_odd
      assign w_par_bad = ~((^r_shift) ^ w_maj);
    end else begin : g_par_none
      assign w_par_bad = 1'b0;
    end
  endgenerate

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .load_val(C_HALF_BIT),
    .en      (w_tmr_en),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync3    <= 1'b1;
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_tap0     <= 1'b1;
      r_tap1     <= 1'b1;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pend  <= w_expire;
      if (w_expire) begin
        r_tap0 <= r_sync3;
        r_tap1 <= r_sync2;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
          end
        end
        ST_START: begin
          if (r_pend) r_state <= w_maj ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (r_pend) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_idx == C_LAST_BIT) begin
              r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (r_pend) begin
            r_perr  <= w_par_bad;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (r_pend) begin
            if (!w_maj) r_ferr <= 1'b1;
            if (r_stop_idx == C_LAST_STOP) begin
              r_state <= ST_DELIVER;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        ST_DELIVER: begin
          // A line still low after a framing error is a break: park until it rises.
          r_state <= (r_ferr && !r_sync2) ? ST_WAIT_HIGH : ST_IDLE;
        end
        ST_WAIT_HIGH: begin
          if (r_sync2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A handshake in the DELIVER cycle frees the holding register first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_state == ST_DELIVER) begin
      if (r_valid && !ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_data       <= r_shift;
        r_frame_err  <= r_ferr;
        r_parity_err <= r_perr;
        r_valid      <= 1'b1;
        r_overrun    <= 1'b0;
      end
    end else if (r_valid && ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
